reg_access_seq: RTL and testbench



---
 rtl/reg_access_seq.sv | 198 +++++++++++++++++++
 tb/tb_reg_access_seq.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_access_seq.sv
// reg_access_seq: sequences one decoded operation through a 16x32 register
// bank with a one-cycle registered read port and a falling-edge, active-low
// write port, handing operands to the ALU with a valid/ready style handshake.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake (ready only in IDLE)
//   req_rn/req_rm/req_rd/req_wb decoded operation fields
//   rf_a1/rf_a2, rf_rd1/rf_rd2 bank read addresses and read data
//   rf_a3/rf_wd3/rf_we3_n      bank write address, data, active-low enable
//   op_valid/op_a/op_b         operands to the ALU
//   res_valid/res_data         result from the ALU
//   done                       one-cycle completion pulse
//   busy                       high in every state except IDLE
//
// Build option: define REGSEQ_PC_WB_BLOCK_EN to suppress write-back to R15.
module reg_access_seq #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_rn,
  input  logic [AW-1:0] req_rm,
  input  logic [AW-1:0] req_rd,
  input  logic          req_wb,
  output logic [AW-1:0] rf_a1,
  output logic [AW-1:0] rf_a2,
  input  logic [DW-1:0] rf_rd1,
  input  logic [DW-1:0] rf_rd2,
  output logic [AW-1:0] rf_a3,
  output logic [DW-1:0] rf_wd3,
  output logic          rf_we3_n,
  output logic          op_valid,
  output logic [DW-1:0] op_a,
  output logic [DW-1:0] op_b,
  input  logic          res_valid,
  input  logic [DW-1:0] res_data,
  output logic          done,
  output logic          busy
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_CAPT = 3'd2,
    S_EXEC = 3'd3,
    S_WB   = 3'd4
  } state_t;

`ifdef REGSEQ_PC_WB_BLOCK_EN
  localparam logic [AW-1:0] PC_REG = AW'(15);
`endif

  state_t        state_q, state_d;
  logic [AW-1:0] rd_q, rd_d;
  logic          wb_q, wb_d;
  logic [AW-1:0] rf_a1_q, rf_a1_d;
  logic [AW-1:0] rf_a2_q, rf_a2_d;
  logic [AW-1:0] rf_a3_q, rf_a3_d;
  logic [DW-1:0] rf_wd3_q, rf_wd3_d;
  logic          rf_we3_n_q, rf_we3_n_d;
  logic          op_valid_q, op_valid_d;
  logic [DW-1:0] op_a_q, op_a_d;
  logic [DW-1:0] op_b_q, op_b_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic          req_ready_q, req_ready_d;
  logic          wb_take;

  // Whether the latched operation actually writes back.
`ifdef REGSEQ_PC_WB_BLOCK_EN
  assign wb_take = wb_q && (rd_q != PC_REG);
`else
  assign wb_take = wb_q;
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    rd_d        = rd_q;
    wb_d        = wb_q;
    rf_a1_d     = rf_a1_q;
    rf_a2_d     = rf_a2_q;
    rf_a3_d     = rf_a3_q;
    rf_wd3_d    = rf_wd3_q;
    rf_we3_n_d  = rf_we3_n_q;
    op_valid_d  = op_valid_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    done_d      = 1'b0;
    busy_d      = busy_q;
    req_ready_d = req_ready_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          rd_d        = req_rd;
          wb_d        = req_wb;
          rf_a1_d     = req_rn;
          rf_a2_d     = req_rm;
          req_ready_d = 1'b0;
          busy_d      = 1'b1;
          state_d     = S_ADDR;
        end
      end
      // Bank samples the held addresses at the closing edge.
      S_ADDR: state_d = S_CAPT;
      S_CAPT: begin
        op_a_d     = rf_rd1;
        op_b_d     = rf_rd2;
        op_valid_d = 1'b1;
        state_d    = S_EXEC;
      end
      S_EXEC: begin
        if (res_valid) begin
          op_valid_d = 1'b0;
          if (wb_take) begin
            rf_wd3_d   = res_data;
            rf_a3_d    = rd_q;
            rf_we3_n_d = 1'b0;
            state_d    = S_WB;
          end else begin
            done_d      = 1'b1;
            req_ready_d = 1'b1;
            busy_d      = 1'b0;
            state_d     = S_IDLE;
          end
        end
      end
      // Enable low for exactly this cycle; bank commits on its falling edge.
      S_WB: begin
        rf_we3_n_d  = 1'b1;
        done_d      = 1'b1;
        req_ready_d = 1'b1;
        busy_d      = 1'b0;
        state_d     = S_IDLE;
      end
      default: begin
        op_valid_d  = 1'b0;
        rf_we3_n_d  = 1'b1;
        req_ready_d = 1'b1;
        busy_d      = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rd_q        <= '0;
      wb_q        <= 1'b0;
      rf_a1_q     <= '0;
      rf_a2_q     <= '0;
      rf_a3_q     <= '0;
      rf_wd3_q    <= '0;
      rf_we3_n_q  <= 1'b1;
      op_valid_q  <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      req_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      rd_q        <= rd_d;
      wb_q        <= wb_d;
      rf_a1_q     <= rf_a1_d;
      rf_a2_q     <= rf_a2_d;
      rf_a3_q     <= rf_a3_d;
      rf_wd3_q    <= rf_wd3_d;
      rf_we3_n_q  <= rf_we3_n_d;
      op_valid_q  <= op_valid_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      req_ready_q <= req_ready_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rf_a1     = rf_a1_q;
  assign rf_a2     = rf_a2_q;
  assign rf_a3     = rf_a3_q;
  assign rf_wd3    = rf_wd3_q;
  assign rf_we3_n  = rf_we3_n_q;
  assign op_valid  = op_valid_q;
  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign done      = done_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_reg_access_seq.sv
// Bench for reg_access_seq: behavioural 16x32 register bank (registered
// read, falling-edge active-low write, PC substituted for R15 writes),
// a vector table of single operations and hand-written reset/back-to-back
// sequences.
module tb_reg_access_seq;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 4;
  localparam logic [31:0] PC_VAL = 32'hC0DE_0000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, req_wb;
  logic [AW-1:0] req_rn, req_rm, req_rd;
  logic [AW-1:0] rf_a1, rf_a2, rf_a3;
  logic [DW-1:0] rf_rd1, rf_rd2, rf_wd3;
  logic          rf_we3_n, op_valid, res_valid, done, busy;
  logic [DW-1:0] op_a, op_b, res_data;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  reg_access_seq #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rn(req_rn), .req_rm(req_rm), .req_rd(req_rd), .req_wb(req_wb),
    .rf_a1(rf_a1), .rf_a2(rf_a2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .rf_a3(rf_a3), .rf_wd3(rf_wd3), .rf_we3_n(rf_we3_n),
    .op_valid(op_valid), .op_a(op_a), .op_b(op_b),
    .res_valid(res_valid), .res_data(res_data),
    .done(done), .busy(busy)
  );

  // Register bank model.
  logic [31:0] regs [16];
  logic        bank_init;

  always @(posedge clk) begin
    rf_rd1 <= regs[rf_a1];
    rf_rd2 <= regs[rf_a2];
  end

  always @(negedge clk) begin
    if (bank_init) begin
      for (int i = 0; i < 16; i++) regs[i] <= 32'h100 + 32'(i);
      regs[2] <= 32'd5;
      regs[3] <= 32'd7;
    end else if (!rf_we3_n) begin
      regs[rf_a3] <= (rf_a3 == 4'd15) ? PC_VAL : rf_wd3;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  rn, rm, rd;
    logic        wb;
    int          delay;
    logic [31:0] res;
    logic [31:0] exp_a, exp_b;
    int          exp_done;
    int          exp_we_low;
    logic [31:0] exp_rd_val;
  } vec_t;

  vec_t vecs [5];

  // Issue one operation and check it through to done.
  task automatic run_op(input vec_t v);
    int cyc, done_cyc, we_low;
    logic [3:0]  cap_a3;
    logic [31:0] cap_wd3;
    cyc = 0; done_cyc = -1; we_low = 0; cap_a3 = '0; cap_wd3 = '0;
    @(negedge clk);
    req_rn = v.rn; req_rm = v.rm; req_rd = v.rd; req_wb = v.wb; req_valid = 1'b1;
    chk("ready_before_accept", 32'(req_ready), 32'd1);
    while (done_cyc < 0 && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        req_valid = 1'b0;
        chk("rf_a1", 32'(rf_a1), 32'(v.rn));
        chk("rf_a2", 32'(rf_a2), 32'(v.rm));
        chk("busy_after_accept", 32'(busy), 32'd1);
        chk("ready_after_accept", 32'(req_ready), 32'd0);
      end
      if (cyc == 2) chk("op_valid_early", 32'(op_valid), 32'd0);
      if (cyc >= 3 && cyc <= 3 + v.delay) begin
        chk("op_valid_exec", 32'(op_valid), 32'd1);
        chk("op_a", op_a, v.exp_a);
        chk("op_b", op_b, v.exp_b);
      end
      res_valid = (cyc == 3 + v.delay);
      res_data  = v.res;
      if (!rf_we3_n) begin
        we_low++;
        cap_a3  = rf_a3;
        cap_wd3 = rf_wd3;
      end
      if (done) begin
        done_cyc = cyc;
        chk("ready_at_done", 32'(req_ready), 32'd1);
        chk("busy_at_done", 32'(busy), 32'd0);
        chk("op_valid_at_done", 32'(op_valid), 32'd0);
      end
    end
    res_valid = 1'b0;
    chk("done_cycle", 32'(done_cyc), 32'(v.exp_done));
    @(negedge clk);
    chk("done_cleared", 32'(done), 32'd0);
    if (!rf_we3_n) we_low++;
    chk("we_low_cycles", 32'(we_low), 32'(v.exp_we_low));
    if (v.exp_we_low != 0) begin
      chk("rf_a3", 32'(cap_a3), 32'(v.rd));
      chk("rf_wd3", cap_wd3, v.res);
    end
    chk("bank_rd_value", regs[v.rd], v.exp_rd_val);
  endtask

  initial begin
    int acc, dn, we_lows;
    rst_n = 1'b0; bank_init = 1'b1;
    req_valid = 1'b0; req_rn = '0; req_rm = '0; req_rd = '0; req_wb = 1'b0;
    res_valid = 1'b0; res_data = '0;

    //            rn     rm     rd     wb    dly res            a          b          done we  rd value
    vecs[0] = '{4'd2, 4'd3, 4'd4, 1'b1, 0, 32'd12,        32'd5,     32'd7,     5, 1, 32'd12};
    vecs[1] = '{4'd2, 4'd3, 4'd4, 1'b0, 3, 32'd99,        32'd5,     32'd7,     7, 0, 32'd12};
    vecs[2] = '{4'd5, 4'd5, 4'd5, 1'b1, 1, 32'h1234,      32'h105,   32'h105,   6, 1, 32'h1234};
    vecs[3] = '{4'd4, 4'd2, 4'd6, 1'b1, 0, 32'h11,        32'd12,    32'd5,     5, 1, 32'h11};
`ifdef REGSEQ_PC_WB_BLOCK_EN
    vecs[4] = '{4'd0, 4'd1, 4'd15, 1'b1, 0, 32'hDEADBEEF, 32'h100,   32'h101,   4, 0, 32'h10F};
`else
    vecs[4] = '{4'd0, 4'd1, 4'd15, 1'b1, 0, 32'hDEADBEEF, 32'h100,   32'h101,   5, 1, PC_VAL};
`endif

    // Reset values
    @(negedge clk); @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_op_valid", 32'(op_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_we3_n", 32'(rf_we3_n), 32'd1);
    chk("rst_addrs", {20'd0, rf_a1, rf_a2, rf_a3}, 32'd0);
    chk("rst_wd3", rf_wd3, 32'd0);
    chk("rst_op_a", op_a, 32'd0);
    chk("rst_op_b", op_b, 32'd0);
    rst_n = 1'b1; bank_init = 1'b0;

    for (int i = 0; i < 5; i++) run_op(vecs[i]);

    // req_valid held high with ALU always ready: accepts every 4 cycles.
    @(negedge clk);
    req_rn = 4'd2; req_rm = 4'd3; req_rd = 4'd7; req_wb = 1'b0;
    req_valid = 1'b1; res_valid = 1'b1; res_data = 32'h77;
    acc = 0; dn = 0; we_lows = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 12) req_valid = 1'b0;
      if (req_ready && req_valid) acc++;
      if (done) dn++;
      if (!rf_we3_n) we_lows++;
      if (busy) chk("ready_low_while_busy", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    res_valid = 1'b0;
    chk("b2b_accepts", 32'(acc), 32'd3);
    chk("b2b_dones", 32'(dn), 32'd3);
    chk("b2b_no_write", 32'(we_lows), 32'd0);
    chk("b2b_r7", regs[7], 32'h107);

    // Reset mid-EXEC, then a late res_valid.
    req_rn = 4'd2; req_rm = 4'd3; req_rd = 4'd9; req_wb = 1'b1; req_valid = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) req_valid = 1'b0;
    end
    chk("exec_op_valid", 32'(op_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_exec_op_valid", 32'(op_valid), 32'd0);
    chk("rst_exec_we3_n", 32'(rf_we3_n), 32'd1);
    chk("rst_exec_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1; res_valid = 1'b1; res_data = 32'h99;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("late_res_no_done", 32'(done), 32'd0);
      chk("late_res_no_write", 32'(rf_we3_n), 32'd1);
    end
    res_valid = 1'b0;
    chk("late_res_r9", regs[9], 32'h109);

    // Reset in WB before the falling edge aborts the write.
    @(negedge clk);
    req_rn = 4'd0; req_rm = 4'd1; req_rd = 4'd8; req_wb = 1'b1; req_valid = 1'b1;
    res_data = 32'h55;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c == 1) req_valid = 1'b0;
    end
    res_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("wb_we3_n_low", 32'(rf_we3_n), 32'd0);
    rst_n = 1'b0; res_valid = 1'b0;
    #1;
    chk("rst_wb_we3_n", 32'(rf_we3_n), 32'd1);
    chk("rst_wb_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("rst_wb_r8", regs[8], 32'h108);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
